keypad_scan_ctrl: RTL and testbench

//  Scan controller for the 3x4 PMOD keypad: drives rows one at a time and samples the columns.

---
 rtl/keypad_pkg.sv | 32 +++
 rtl/key_fifo.sv | 58 +++++
 rtl/keypad_scan_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types, constants and key encoding for the 3x4 keypad scan controller.
// The code map is row-major, 1-9 on rows 0-2; row 3 holds '*', '0' and '#'.
package keypad_pkg;

   localparam int N_ROWS = 4;
   localparam int N_COLS = 3;
   localparam int N_KEYS = N_ROWS * N_COLS;

   localparam logic [3:0] KEY_STAR  = 4'd10;
   localparam logic [3:0] KEY_POUND = 4'd11;

   typedef enum logic [1:0] {ROW0, ROW1, ROW2, ROW3} scan_state_t;

   typedef enum logic {RELEASED, PRESSED} deb_state_t;

   typedef enum logic [1:0] {SCAN_NONE, SCAN_KEY, SCAN_MULTI} scan_kind_t;

   function automatic logic [3:0] encode_key(input logic [1:0] row, input logic [1:0] col);
      logic [3:0] code;
      if (row == 2'd3) begin
         case (col)
            2'd0:    code = KEY_STAR;
            2'd1:    code = 4'd0;
            default: code = KEY_POUND;
         endcase
      end else begin
         code = {2'b00, row} * 4'd3 + {2'b00, col} + 4'd1;
      end
      return code;
   endfunction

endpackage

// File: rtl/key_fifo.sv
// Small synchronous FIFO for key events; head is visible combinationally from storage.
// Simultaneous push and pop is accepted even when full.
module key_fifo #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           dout,
   output logic                       empty,
   output logic                       full,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      cnt;
   logic             do_push;
   logic             do_pop;

   assign empty   = (cnt == '0);
   assign full    = (cnt == (AW+1)'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign count   = cnt;
   assign dout    = empty ? '0 : mem[rd_ptr];

   // NOTE: storage is deliberately not reset; dout is forced to zero while empty,
   // so stale contents are never observable.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // NOTE: all sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Row-scanning keypad controller: synchronizes columns, classifies each full scan,
// debounces presses, queues key codes and pulses an interrupt toward the MCU.
module keypad_scan_ctrl
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV       = 22727,
   parameter int DEBOUNCE_SCANS = 3,
   parameter int FIFO_DEPTH     = 4,
   parameter int INT_CYCLES     = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [2:0]  cols,
   output logic [3:0]  rows,
   output logic [3:0]  key_code,
   output logic        key_valid,
   input  logic        key_ack,
   output logic        interrupt,
   output logic        overflow,
   input  logic        clr_ovf
);

   localparam int DIV_W    = $clog2(SCAN_DIV + 1);
   localparam int STREAK_W = $clog2(DEBOUNCE_SCANS + 1);
   localparam int INT_W    = $clog2(INT_CYCLES + 1);
   localparam int CNT_W    = $clog2(FIFO_DEPTH) + 1;

   logic [2:0]          cols_meta;
   logic [2:0]          cols_sync;
   scan_state_t         scan_state;
   scan_state_t         scan_next;
   logic [DIV_W-1:0]    dwell_cnt;
   logic                sample;
   logic                scan_end;
   logic [8:0]          scan_acc;
   logic [N_KEYS-1:0]   full_scan;
   logic [3:0]          n_set;
   logic [3:0]          scan_code;
   scan_kind_t          scan_kind;

   deb_state_t          deb_state;
   deb_state_t          deb_next;
   logic [3:0]          cand_code;
   logic [3:0]          cand_next;
   logic [STREAK_W-1:0] streak;
   logic [STREAK_W-1:0] streak_next;
   logic [STREAK_W-1:0] streak_inc;
   logic [STREAK_W-1:0] press_run;
   logic                push_req;

   logic                fifo_pop;
   logic                fifo_empty;
   logic                fifo_full;
   logic [CNT_W-1:0]    fifo_count;
   logic                drop;
   logic                int_trig;
   logic [INT_W-1:0]    int_cnt;

   // Columns are asynchronous to clk.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cols_meta <= '0;
         cols_sync <= '0;
      end else begin
         cols_meta <= cols;
         cols_sync <= cols_meta;
      end
   end

   assign sample   = (dwell_cnt == DIV_W'(SCAN_DIV - 1));
   assign scan_end = sample && (scan_state == ROW3);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scan_state <= ROW0;
         dwell_cnt  <= '0;
      end else begin
         scan_state <= scan_next;
         dwell_cnt  <= sample ? '0 : dwell_cnt + 1'b1;
      end
   end

   // NOTE: every always_comb output gets a default before any branch, so no
   // path leaves a signal unassigned and no latch is inferred.
   always_comb begin
      scan_next = scan_state;
      if (sample) begin
         case (scan_state)
            ROW0:    scan_next = ROW1;
            ROW1:    scan_next = ROW2;
            ROW2:    scan_next = ROW3;
            default: scan_next = ROW0;
         endcase
      end
   end

   always_comb begin
      rows = 4'b0001;
      case (scan_state)
         ROW1:    rows = 4'b0010;
         ROW2:    rows = 4'b0100;
         ROW3:    rows = 4'b1000;
         default: rows = 4'b0001;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scan_acc <= '0;
      end else if (sample) begin
         case (scan_state)
            ROW0:    scan_acc[2:0] <= cols_sync;
            ROW1:    scan_acc[5:3] <= cols_sync;
            ROW2:    scan_acc[8:6] <= cols_sync;
            default: scan_acc      <= scan_acc;
         endcase
      end
   end

   // Row 3 is taken straight from the synchronizer on the final sample cycle.
   assign full_scan = {cols_sync, scan_acc};

   always_comb begin
      n_set     = '0;
      scan_code = '0;
      for (int i = 0; i < N_KEYS; i++) begin
         if (full_scan[i]) begin
            n_set     = n_set + 4'd1;
            scan_code = encode_key(2'(i / N_COLS), 2'(i % N_COLS));
         end
      end
      if (n_set == 4'd0)      scan_kind = SCAN_NONE;
      else if (n_set == 4'd1) scan_kind = SCAN_KEY;
      else                    scan_kind = SCAN_MULTI;
   end

   assign streak_inc = streak + 1'b1;
   assign press_run  = ((streak != '0) && (scan_code == cand_code)) ? streak_inc
                                                                     : STREAK_W'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         deb_state <= RELEASED;
         cand_code <= '0;
         streak    <= '0;
      end else begin
         deb_state <= deb_next;
         cand_code <= cand_next;
         streak    <= streak_next;
      end
   end

   // MULTI scans fall through every branch and freeze the debouncer.
   always_comb begin
      deb_next    = deb_state;
      cand_next   = cand_code;
      streak_next = streak;
      push_req    = 1'b0;
      if (scan_end) begin
         case (deb_state)
            RELEASED: begin
               if (scan_kind == SCAN_KEY) begin
                  cand_next = scan_code;
                  if (press_run == STREAK_W'(DEBOUNCE_SCANS)) begin
                     deb_next    = PRESSED;
                     streak_next = '0;
                     push_req    = 1'b1;
                  end else begin
                     streak_next = press_run;
                  end
               end else if (scan_kind == SCAN_NONE) begin
                  streak_next = '0;
               end
            end
            default: begin
               if (scan_kind == SCAN_NONE) begin
                  if (streak_inc == STREAK_W'(DEBOUNCE_SCANS)) begin
                     deb_next    = RELEASED;
                     streak_next = '0;
                  end else begin
                     streak_next = streak_inc;
                  end
               end else if (scan_kind == SCAN_KEY) begin
                  streak_next = '0;
               end
            end
         endcase
      end
   end

   assign fifo_pop  = key_ack && key_valid;
   assign key_valid = !fifo_empty;

   key_fifo #(
      .WIDTH (4),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push_req),
      .pop   (fifo_pop),
      .din   (scan_code),
      .dout  (key_code),
      .empty (fifo_empty),
      .full  (fifo_full),
      .count (fifo_count)
   );

   assign drop = push_req && fifo_full && !fifo_pop;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       overflow <= 1'b0;
      else if (drop)    overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
   end

   // A pop with a simultaneous push always leaves the FIFO non-empty.
   assign int_trig = (push_req && fifo_empty) ||
                     (fifo_pop && ((fifo_count > CNT_W'(1)) || push_req));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                int_cnt <= '0;
      else if (int_trig)         int_cnt <= INT_W'(INT_CYCLES);
      else if (int_cnt != '0)    int_cnt <= int_cnt - 1'b1;
   end

   assign interrupt = (int_cnt != '0);

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl with a scan-level behavioural model and
// per-cycle comparison, plus literal expectations for each scenario.
module tb_keypad_scan_ctrl;

   localparam int SCAN_DIV   = 4;
   localparam int DEB        = 2;
   localparam int DEPTH      = 4;
   localparam int INT_CYC    = 3;
   localparam int SCAN_LEN   = 4 * SCAN_DIV;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [2:0]  cols;
   logic [3:0]  rows;
   logic [3:0]  key_code;
   logic        key_valid;
   logic        key_ack = 1'b0;
   logic        interrupt;
   logic        overflow;
   logic        clr_ovf = 1'b0;

   logic [11:0] keys = '0;   // bit r*3+c = key at row r, col c held down

   int n_tests = 0;
   int n_fail  = 0;

   keypad_scan_ctrl #(
      .SCAN_DIV       (SCAN_DIV),
      .DEBOUNCE_SCANS (DEB),
      .FIFO_DEPTH     (DEPTH),
      .INT_CYCLES     (INT_CYC)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cols      (cols),
      .rows      (rows),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_ack   (key_ack),
      .interrupt (interrupt),
      .overflow  (overflow),
      .clr_ovf   (clr_ovf)
   );

   always #5 clk = ~clk;

   // Physical keypad: a column reads high if any held key on a driven row sits in it.
   always_comb begin
      cols = '0;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 3; c++)
            if (rows[r] && keys[r*3+c]) cols[c] = 1'b1;
   end

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   const int code_tab [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 0, 11};
   int edge_cnt  = 0;
   int last_trig = -1000;
   bit m_pressed = 0;
   bit m_ovf     = 0;
   int m_hist [$];   // recent non-MULTI scan results, -1 = no key
   int m_q    [$];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         edge_cnt  = 0;
         last_trig = -1000;
         m_pressed = 0;
         m_ovf     = 0;
         m_hist.delete();
         m_q.delete();
      end else begin
         bit push, pop_ok, was_empty, all_same;
         int push_code, sz0, nk, res;
         edge_cnt++;
         push = 0;
         push_code = 0;
         if (edge_cnt % SCAN_LEN == 0) begin
            nk = $countones(keys);
            if (nk <= 1) begin
               res = -1;
               for (int b = 0; b < 12; b++) if (keys[b]) res = code_tab[b];
               m_hist.push_back(res);
               if (m_hist.size() > DEB) void'(m_hist.pop_front());
               all_same = (m_hist.size() == DEB);
               foreach (m_hist[i]) if (m_hist[i] != m_hist[0]) all_same = 0;
               if (all_same && !m_pressed && m_hist[0] >= 0) begin
                  push = 1;
                  push_code = m_hist[0];
                  m_pressed = 1;
                  m_hist.delete();
               end else if (all_same && m_pressed && m_hist[0] < 0) begin
                  m_pressed = 0;
                  m_hist.delete();
               end
            end
         end
         was_empty = (m_q.size() == 0);
         sz0 = m_q.size();
         pop_ok = key_ack && (sz0 > 0);
         if (pop_ok) void'(m_q.pop_front());
         if (push) begin
            if (sz0 < DEPTH || pop_ok) m_q.push_back(push_code);
            else                       m_ovf = 1;
         end
         if (!(push && sz0 >= DEPTH && !pop_ok) && clr_ovf) m_ovf = 0;
         if ((was_empty && m_q.size() > 0) || (pop_ok && m_q.size() > 0))
            last_trig = edge_cnt;
      end
   end

   always @(negedge clk) begin
      int d;
      d = edge_cnt - last_trig;
      check("rows", rows, 1 << ((edge_cnt % SCAN_LEN) / SCAN_DIV));
      check("key_valid", key_valid, m_q.size() > 0);
      check("key_code", key_code, (m_q.size() > 0) ? m_q[0] : 0);
      check("interrupt", interrupt, (d >= 0 && d < INT_CYC) ? 1 : 0);
      check("overflow", overflow, m_ovf);
   end

   // ---------------- stimulus helpers ----------------
   task automatic wait_scans(input int n);
      repeat (n) begin
         @(negedge clk);
         while (edge_cnt % SCAN_LEN != 0) @(negedge clk);
      end
   endtask

   task automatic do_ack();
      key_ack = 1'b1;
      @(negedge clk);
      key_ack = 1'b0;
   endtask

   task automatic tap(input int bit_idx);
      keys = 12'(1) << bit_idx;
      wait_scans(DEB);
      keys = '0;
      wait_scans(DEB);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int pulses;
      int drain [4] = '{3, 4, 9, 7};

      // 1: reset mid-scan with '5' held
      keys = 12'(1) << 4;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      wait_scans(1);
      check("t1_one_scan_no_event", key_valid, 0);
      repeat (7) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("t1_rst_rows", rows, 4'b0001);
      check("t1_rst_valid", key_valid, 0);
      check("t1_rst_int", interrupt, 0);
      check("t1_rst_ovf", overflow, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      wait_scans(1);
      check("t1_partial_debounce", key_valid, 0);

      // 2: '5' accepted after the second scan, one pulse, no repeat
      wait_scans(1);
      check("t2_valid", key_valid, 1);
      check("t2_code", key_code, 5);
      pulses = 0;
      repeat (5) begin
         pulses += interrupt;
         @(negedge clk);
      end
      check("t2_int_len", pulses, 3);
      wait_scans(2);
      check("t2_held_code", key_code, 5);
      keys = '0;
      wait_scans(2);
      do_ack();
      check("t2_single_event", key_valid, 0);

      // 3: one-scan glitch on '8'
      keys = 12'(1) << 7;
      wait_scans(1);
      keys = '0;
      wait_scans(2);
      check("t3_glitch", key_valid, 0);

      // 4: '1'+'3' together is MULTI, then '#'
      keys = 12'b0000_0000_0101;
      wait_scans(3);
      check("t4_multi", key_valid, 0);
      keys = '0;
      wait_scans(1);
      keys = 12'(1) << 11;
      wait_scans(2);
      check("t4_pound_valid", key_valid, 1);
      check("t4_pound_code", key_code, 11);
      keys = '0;
      wait_scans(2);
      do_ack();
      check("t4_drained", key_valid, 0);

      // 5: five keys into a four-deep queue
      tap(0); tap(1); tap(2); tap(3); tap(5);
      check("t5_ovf", overflow, 1);
      check("t5_head", key_code, 1);
      do_ack();
      check("t5_after_ack", key_code, 2);
      check("t5_ack_int", interrupt, 1);
      clr_ovf = 1'b1;
      @(negedge clk);
      clr_ovf = 1'b0;
      check("t5_clr_ovf", overflow, 0);

      // 6: fill with '9', then push '7' on the same edge as an ack
      tap(8);
      check("t6_full_no_ovf", overflow, 0);
      check("t6_full_head", key_code, 2);
      keys = 12'(1) << 6;
      wait_scans(1);
      @(negedge clk);
      while (edge_cnt % SCAN_LEN != SCAN_LEN - 1) @(negedge clk);
      do_ack();
      check("t6_push_pop_ovf", overflow, 0);
      check("t6_push_pop_head", key_code, 3);
      keys = '0;
      wait_scans(2);
      foreach (drain[i]) begin
         check("t6_drain", key_code, drain[i]);
         do_ack();
      end
      check("t6_empty", key_valid, 0);
      repeat (3) @(negedge clk);
      do_ack();
      check("t6_ack_empty_valid", key_valid, 0);
      check("t6_ack_empty_int", interrupt, 0);
      repeat (4) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
